// File: rtl/pipe_drain_buffer_if.sv
// Handshake/bus bundle for pipe_drain_buffer: non-refusable ingress stream,
// valid/accept egress, and status back to the pipeline.
interface pipe_drain_buffer_if #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [W-1:0]     in;
  logic             in_vld;
  logic [W-1:0]     out;
  logic             out_vld;
  logic             out_accept;
  logic             stall_r;
  logic [OCC_W-1:0] occ_r;
  logic             overflow_r;

  modport master (
    output in, in_vld, out_accept,
    input  out, out_vld, stall_r, occ_r, overflow_r
  );

  modport slave (
    input  in, in_vld, out_accept,
    output out, out_vld, stall_r, occ_r, overflow_r
  );
endinterface

// File: rtl/pipe_drain_buffer.sv
// Output FIFO for an unstallable pipeline tail, with early registered stall.
// Optional same-cycle bypass when empty: define PIPE_DRAIN_BYPASS_EN.
module pipe_drain_buffer #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned SKID  = 10
) (
  input logic                clk,
  input logic                rst,
  pipe_drain_buffer_if.slave bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL   = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] THRESH = OCC_W'(DEPTH - SKID);
  localparam logic [PTR_W-1:0] LAST   = PTR_W'(DEPTH - 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wp, rp;
  logic [OCC_W-1:0] occ, occ_next;
  logic             stall, overflow;
  logic             empty, full, pop, write, drop;

  assign empty = (occ == '0);
  assign full  = (occ == FULL);
  // pop only counts entries leaving storage; a bypassed result never enters it
  assign pop   = !empty && bus.out_accept;

`ifdef PIPE_DRAIN_BYPASS_EN
  assign write       = bus.in_vld && (!full || pop) && !(empty && bus.out_accept);
  assign bus.out_vld = !empty || bus.in_vld;
  assign bus.out     = empty ? bus.in : mem[rp];
`else
  assign write       = bus.in_vld && (!full || pop);
  assign bus.out_vld = !empty;
  assign bus.out     = mem[rp];
`endif

  assign drop = bus.in_vld && full && !pop;

  always_comb begin
    occ_next = occ;
    if (write && !pop)
      occ_next = occ + 1'b1;
    else if (!write && pop)
      occ_next = occ - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      occ      <= '0;
      stall    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (write)
        wp <= (wp == LAST) ? '0 : wp + 1'b1;
      if (pop)
        rp <= (rp == LAST) ? '0 : rp + 1'b1;
      occ   <= occ_next;
      stall <= (occ_next >= THRESH);
      if (drop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && write)
      mem[wp] <= bus.in;
  end

  assign bus.occ_r      = occ;
  assign bus.stall_r    = stall;
  assign bus.overflow_r = overflow;
endmodule

// File: tb/tb_pipe_drain_buffer.sv
// Scoreboard bench: drivers queue expected egress words, monitors pop and compare.
module tb_pipe_drain_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_drain_buffer_if #(.W(32), .DEPTH(16)) b ();
  pipe_drain_buffer_if #(.W(32), .DEPTH(12)) b2 ();

  pipe_drain_buffer #(.W(32), .DEPTH(16), .SKID(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  pipe_drain_buffer #(.W(32), .DEPTH(12), .SKID(4)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  int nchk = 0;
  int nerr = 0;
  int pops2 = 0;
  logic [31:0] q[$];
  logic [31:0] q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors sample 4ns after the falling edge, i.e. just before the rising edge.
  always begin
    @(negedge clk);
    #4;
    if (!rst && b.out_vld && b.out_accept) begin
      if (q.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL mon_unexpected: got %h expected no output", b.out);
      end else
        check("mon_data", b.out, q.pop_front());
    end
  end

  always begin
    @(negedge clk);
    #4;
    if (!rst && b2.out_vld && b2.out_accept) begin
      pops2++;
      if (q2.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL mon2_unexpected: got %h expected no output", b2.out);
      end else
        check("mon2_data", b2.out, q2.pop_front());
    end
  end

  // One cycle on the 16-deep instance; returns at the pre-edge sample point.
  task automatic cyc(input logic r, input logic v, input logic [31:0] d,
                     input logic a, input bit keep);
    @(negedge clk);
    rst          = r;
    b.in_vld     = v;
    b.in         = d;
    b.out_accept = a;
    if (r) q.delete();
    else if (keep) q.push_back(d);
    #4;
  endtask

  initial begin
    int cnt;
    b.in_vld = 0; b.in = '0; b.out_accept = 0;
    b2.in_vld = 0; b2.in = '0; b2.out_accept = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("rst_occ", 32'(b.occ_r), 0);
    check("rst_vld", 32'(b.out_vld), 0);
    check("rst_stall", 32'(b.stall_r), 0);
    check("rst_ovf", 32'(b.overflow_r), 0);
    cyc(0, 0, 0, 0, 0);

    // Single push latency
    cyc(0, 1, 32'hA5A5_0001, 1, 1);
`ifdef PIPE_DRAIN_BYPASS_EN
    check("lat_t_vld", 32'(b.out_vld), 1);
    check("lat_t_data", b.out, 32'hA5A5_0001);
    cyc(0, 0, 0, 1, 0);
    check("lat_t1_vld", 32'(b.out_vld), 0);
`else
    check("lat_t_vld", 32'(b.out_vld), 0);
    cyc(0, 0, 0, 1, 0);
    check("lat_t1_vld", 32'(b.out_vld), 1);
    check("lat_t1_data", b.out, 32'hA5A5_0001);
`endif
    cyc(0, 0, 0, 0, 0);
    check("lat_t2_vld", 32'(b.out_vld), 0);
    check("lat_occ", 32'(b.occ_r), 0);

    // Stall threshold at DEPTH-SKID = 6
    for (int i = 1; i <= 6; i++) begin
      cyc(0, 1, 32'(i), 0, 1);
      if (i == 6) check("stall_pre", 32'(b.stall_r), 0);
    end
    cyc(0, 0, 0, 0, 0);
    check("stall_rise", 32'(b.stall_r), 1);
    check("stall_occ", 32'(b.occ_r), 6);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 1, 0);
      if (i == 1) begin
        check("stall_fall_occ", 32'(b.occ_r), 5);
        check("stall_fall", 32'(b.stall_r), 0);
      end
    end
    cyc(0, 0, 0, 0, 0);
    check("drain1_occ", 32'(b.occ_r), 0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) cyc(0, 1, 32'h200 + 32'(i), 0, 1);
    cyc(0, 0, 0, 0, 0);
    check("full_occ", 32'(b.occ_r), 16);
    cyc(0, 1, 32'hBEEF, 1, 1);
    cyc(0, 0, 0, 0, 0);
    check("pp_occ", 32'(b.occ_r), 16);
    check("pp_ovf", 32'(b.overflow_r), 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    check("drain2_occ", 32'(b.occ_r), 0);
    check("drain2_vld", 32'(b.out_vld), 0);

    // Overflow: push to full queue without pop is dropped
    for (int i = 0; i < 16; i++) cyc(0, 1, 32'h300 + 32'(i), 0, 1);
    cyc(0, 1, 32'hDEAD, 0, 0);
    check("ovf_pre", 32'(b.overflow_r), 0);
    cyc(0, 0, 0, 0, 0);
    check("ovf_set", 32'(b.overflow_r), 1);
    check("ovf_occ", 32'(b.occ_r), 16);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    check("part_occ", 32'(b.occ_r), 7);
    check("ovf_sticky", 32'(b.overflow_r), 1);

    // Reset mid-operation with a push in the reset cycle
    cyc(1, 1, 32'h777, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("mrst_occ", 32'(b.occ_r), 0);
    check("mrst_vld", 32'(b.out_vld), 0);
    check("mrst_stall", 32'(b.stall_r), 0);
    check("mrst_ovf", 32'(b.overflow_r), 0);
    cyc(0, 0, 0, 0, 0);
    check("mrst_lost", 32'(b.out_vld), 0);

    // Wrap test on the 12-deep instance, pushes gated by stall_r
    cnt = 0;
    for (int c = 0; c < 400 && (cnt < 40 || q2.size() != 0); c++) begin
      @(negedge clk);
      b2.in_vld     = (cnt < 40) && !b2.stall_r;
      b2.in         = 32'(cnt);
      b2.out_accept = (cnt >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
      if (b2.in_vld) begin
        q2.push_back(32'(cnt));
        cnt++;
      end
    end
    @(negedge clk);
    b2.in_vld = 0;
    b2.out_accept = 0;
    #4;
    check("wrap_pushed", 32'(cnt), 40);
    check("wrap_left", 32'(q2.size()), 0);
    check("wrap_pops", 32'(pops2), 40);
    check("wrap_ovf", 32'(b2.overflow_r), 0);
    check("wrap_occ", 32'(b2.occ_r), 0);
    check("main_left", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/pipe_drain_buffer.md
# pipe_drain_buffer

Output-side buffer for the linear stallable pipeline: it captures the pipeline's final-stage result stream, which cannot be stalled, into a FIFO and re-presents it on a valid/accept egress interface. It generates the pipeline's `stall` input early enough that results already in flight always find space. The block sits directly downstream of the pipeline's last stage. Its `stall_r` drives the stall request of the pipeline's last stallable stage.

## Interface
- `W`, 32: data width.
- `DEPTH`, 16: FIFO entries; must be ≥ 2. Need not be a power of 2.
- `SKID`, 10: entries reserved for in-flight results; must be ≥ 1 and < `DEPTH`. Set it ≥ (pipeline depth + 1).
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `in`  in  `W`  result from the final pipeline stage.
- `in_vld`  in  1  result valid. It cannot be refused; a push occurs every cycle it is high.
- `out`  out  `W`  head-of-queue data.
- `out_vld`  out  1  head valid.
- `out_accept`  in  1  consumer takes the head this cycle.
- `stall_r`  out  1  registered backpressure to the pipeline.
- `occ_r`  out  `$clog2(DEPTH+1)`  current occupancy, 0..`DEPTH`.
- `overflow_r`  out  1  sticky error: a push was dropped.

## Operation
- **Storage**
  - `DEPTH`×`W` register array, with write pointer `wp` and read pointer `rp`, each `$clog2(DEPTH)` bits.
  - Each pointer increments on its event and wraps from `DEPTH-1` to 0. Wrap is explicit; it is not a power-of-2 overflow.
- **Push and pop**
  - push = `in_vld` & (`occ_r` < `DEPTH` | pop).
  - pop = `out_vld` & `out_accept`.
- **Occupancy**
  - `occ_r` next = `occ_r` + push − pop.
  - Simultaneous push and pop leaves `occ_r` unchanged and advances both pointers.
- **Full**
  - Push while full with a pop in the same cycle is legal, accepted, and not an overflow.
  - Push while full without a pop: data is dropped, pointers and `occ_r` are unchanged, and `overflow_r` is set. It stays set until `rst`.
- **Empty**
  - `out_vld` = (`occ_r` ≠ 0). `out` = `mem[rp]`.
  - When `out_vld` = 0, `out` is don't-care.
  - `out_accept` with `out_vld` = 0 is ignored.
- **Backpressure**
  - `stall_r` next = (`occ_r` next ≥ `DEPTH` − `SKID`).
  - This is a pure function of next occupancy, with no hysteresis.
- **Reset**
  - On reset: `wp` = `rp` = 0, `occ_r` = 0, `out_vld` = 0, `stall_r` = 0, `overflow_r` = 0.
  - Array contents are not reset.
  - Reset mid-operation discards all queued entries. `in_vld` in the reset cycle is ignored.
- **Egress rule**
  - The consumer may hold `out_accept` low indefinitely. `out` and `out_vld` must stay stable until pop.

## Timing
- Latency with the macro undefined:
  - A push in cycle t makes `out_vld` = 1 at t+1 if the queue was empty.
  - Pop to next head is 0 cycles, because `rp` advances at the clock edge.
- `stall_r` updates one cycle after the push or pop that crosses the threshold.
  - `SKID` must cover this cycle plus all results the pipeline holds beyond the stalled stage.
- Full throughput: one push and one pop per cycle, sustained at any occupancy.
- `occ_r` and `overflow_r` are updated at the clock edge after the event.

## Configuration
- `PIPE_DRAIN_BYPASS_EN`:
  - **Defined**: when `occ_r` = 0 and `in_vld` = 1, then `out_vld` = 1 and `out` = `in` in the same cycle.
    - If `out_accept` = 1, the entry is consumed directly. It is not written and `wp`/`occ_r` are unchanged.
    - Otherwise it is written normally.
    - Egress then depends combinationally on `in_vld` and `in`.
  - **Undefined**: `out`/`out_vld` depend on registers only, with the 1-cycle latency described above.

## Test plan
- Reset, then single push of 0xA5A5_0001 at t=5 with `out_accept` = 1:
  - Without macro: `out_vld` = 1 and `out` = 0xA5A5_0001 at t=6 only.
  - With macro: same values at t=5.
- `DEPTH` = 16, `SKID` = 10, `out_accept` = 0, push values 1..6 on consecutive cycles:
  - `stall_r` rises the cycle after the 6th push.
  - `occ_r` = 6.
  - Values drain in order 1..6 once `out_accept` = 1.
- Fill to 16 with `out_accept` = 0, then push 0xDEAD:
  - `overflow_r` = 1 next cycle, `occ_r` stays 16, and 0xDEAD never appears on `out`.
- Full queue, push 0xBEEF and pop simultaneously:
  - `occ_r` stays 16 and `overflow_r` = 0.
  - 0xBEEF emerges after the 15 older entries.
- `DEPTH` = 12, 40 pushes and pops of an incrementing count with random `out_accept`:
  - Output sequence is 0..39 in order across multiple pointer wraps at 11→0.
- Reset asserted with `occ_r` = 7 and `in_vld` = 1:
  - Next cycle `occ_r` = 0, `out_vld` = 0, `stall_r` = 0, `overflow_r` = 0.
  - The push in the reset cycle is lost.
